// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default sizing for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

    // Adaptor controller states
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned DefLineW  = 256;
    localparam int unsigned DefBurstW = 64;
    localparam int unsigned DefAddrW  = 32;

    // Number of memory beats needed to move one line
    function automatic int unsigned beats_per_line(int unsigned line_w, int unsigned burst_w);
        return line_w / burst_w;
    endfunction

    localparam int unsigned DefBeats = beats_per_line(DefLineW, DefBurstW);

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns whole-line read/write requests into BEATS-long memory
// bursts and assembles returned beats into a line.
// Optional build macro: CACHELINE_ADAPTOR_LINE_ALIGN_EN forces line-aligned address_o.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned LINE_W  = DefLineW,
    parameter int unsigned BURST_W = DefBurstW,
    parameter int unsigned ADDR_W  = DefAddrW
) (
    input  logic               clk,
    input  logic               rst,
    // cache side
    input  logic               read_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    // memory side
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int unsigned    Beats     = beats_per_line(LINE_W, BURST_W);
    localparam int unsigned    CntW      = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    state_e                        state_q;
    logic [CntW-1:0]               count_q;
    logic [CntW-1:0]               count_d;
    logic                          last_beat;
    logic [Beats-1:0][BURST_W-1:0] fill_q;
    logic [Beats-1:0][BURST_W-1:0] fill_d;
    logic [Beats-1:0][BURST_W-1:0] wbuf_q;
    logic [ADDR_W-1:0]             addr_cap;

    // Beat counter advance, fill-slot merge and captured request address
    always_comb begin
        last_beat       = (count_q == LastBeat);
        count_d         = last_beat ? '0 : count_q + CntW'(1);
        fill_d          = fill_q;
        fill_d[count_q] = burst_i;
        addr_cap        = address_i;
`ifdef CACHELINE_ADAPTOR_LINE_ALIGN_EN
        addr_cap[$clog2(LINE_W/8)-1:0] = '0;
`endif
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            fill_q    <= '0;
            wbuf_q    <= '0;
            line_o    <= '0;
            resp_o    <= 1'b0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            burst_o   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Read wins when both requests are raised together
                    if (read_i) begin
                        state_q   <= StRead;
                        address_o <= addr_cap;
                        read_o    <= 1'b1;
                        count_q   <= '0;
                    end else if (write_i) begin
                        state_q   <= StWrite;
                        address_o <= addr_cap;
                        write_o   <= 1'b1;
                        wbuf_q    <= line_i;
                        burst_o   <= line_i[BURST_W-1:0];
                        count_q   <= '0;
                    end
                end
                StRead: begin
                    if (resp_i) begin
                        fill_q  <= fill_d;
                        count_q <= count_d;
                        if (last_beat) begin
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            line_o  <= fill_d;
                            state_q <= StDone;
                        end
                    end
                end
                StWrite: begin
                    if (resp_i) begin
                        count_q <= count_d;
                        burst_o <= wbuf_q[count_d];
                        if (last_beat) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Cache drops its request during this cycle
                    resp_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor (default 256/64/32 sizing).
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic         read_i;
    logic         write_i;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int checks_q;
    int errors_q;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [255:0] exp_line);
        check_eq({tag, "_resp"},  256'(resp_o),    256'(1'b0));
        check_eq({tag, "_read"},  256'(read_o),    256'(1'b0));
        check_eq({tag, "_write"}, 256'(write_o),   256'(1'b0));
        check_eq({tag, "_addr"},  256'(address_o), 256'(32'h0));
        check_eq({tag, "_burst"}, 256'(burst_o),   256'(64'h0));
        check_eq({tag, "_line"},  line_o,          exp_line);
    endtask

    // Line fill; pat gives resp_i per cycle, LSB first, plen cycles long
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic both, input logic [15:0] pat, input int plen,
                           input logic [255:0] line);
        int beat;
        read_i    = 1'b1;
        write_i   = both;
        address_i = addr;
        tick();
        check_eq({tag, "_read_o"},  256'(read_o),    256'(1'b1));
        check_eq({tag, "_write_o"}, 256'(write_o),   256'(1'b0));
        check_eq({tag, "_addr_o"},  256'(address_o), 256'(exp_addr));
        beat = 0;
        for (int i = 0; i < plen; i++) begin
            resp_i  = pat[i];
            burst_i = line[beat*64 +: 64];
            if (pat[i]) beat++;
            tick();
            if (i < plen - 1) begin
                check_eq({tag, "_busy_resp"}, 256'(resp_o), 256'(1'b0));
                check_eq({tag, "_busy_read"}, 256'(read_o), 256'(1'b1));
            end
        end
        resp_i  = 1'b0;
        burst_i = '0;
        check_eq({tag, "_resp_hi"},  256'(resp_o), 256'(1'b1));
        check_eq({tag, "_read_lo"},  256'(read_o), 256'(1'b0));
        check_eq({tag, "_line"},     line_o,       line);
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        check_eq({tag, "_resp_lo"},  256'(resp_o), 256'(1'b0));
        check_eq({tag, "_line_hold"}, line_o,      line);
    endtask

    localparam logic [255:0] FillA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] FillB = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                                      64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    localparam logic [255:0] WrLine = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                       64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};

    initial begin
        logic [31:0] align_exp;
        logic [255:0] wl;
        checks_q  = 0;
        errors_q  = 0;
        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset", 256'h0);
        rst = 1'b0;
        tick();

        // Consecutive-beat fill
        do_read("fill", 32'h0000_1240, 32'h0000_1240, 1'b0, 16'b1111, 4, FillA);

        // Writeback, beats A,B,C,D in order
        wl        = WrLine;
        write_i   = 1'b1;
        line_i    = wl;
        address_i = 32'h0000_2000;
        tick();
        line_i = '0;
        check_eq("wr_write_o", 256'(write_o),   256'(1'b1));
        check_eq("wr_read_o",  256'(read_o),    256'(1'b0));
        check_eq("wr_addr_o",  256'(address_o), 256'(32'h0000_2000));
        check_eq("wr_beat0",   256'(burst_o),   256'(wl[63:0]));
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1;
            tick();
            if (i < 3) begin
                check_eq("wr_beat_next", 256'(burst_o), 256'(wl[(i+1)*64 +: 64]));
                check_eq("wr_busy_wr",   256'(write_o), 256'(1'b1));
                check_eq("wr_busy_resp", 256'(resp_o),  256'(1'b0));
            end
        end
        resp_i = 1'b0;
        check_eq("wr_resp_hi",   256'(resp_o),  256'(1'b1));
        check_eq("wr_write_lo",  256'(write_o), 256'(1'b0));
        check_eq("wr_line_hold", line_o,        FillA);
        write_i = 1'b0;
        tick();
        check_eq("wr_resp_lo", 256'(resp_o), 256'(1'b0));

        // Stalled fill: resp_i 1,0,0,1,1,0,1
        do_read("stall", 32'h0000_3000, 32'h0000_3000, 1'b0, 16'b1011001, 7, FillB);

        // Simultaneous read and write: read serviced
        do_read("both", 32'h0000_4000, 32'h0000_4000, 1'b1, 16'b1111, 4, FillA);

        // Reset after two of four read beats
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = FillB[i*64 +: 64];
            tick();
        end
        resp_i = 1'b0;
        rst    = 1'b1;
        tick();
        read_i = 1'b0;
        check_idle_outputs("midrst", 256'h0);
        rst = 1'b0;
        tick();
        check_eq("midrst_stay_idle", 256'(read_o), 256'(1'b0));
        do_read("postrst", 32'h0000_5000, 32'h0000_5000, 1'b0, 16'b1111, 4, FillB);

        // Address alignment option
`ifdef CACHELINE_ADAPTOR_LINE_ALIGN_EN
        align_exp = 32'h0000_1240;
`else
        align_exp = 32'h0000_125C;
`endif
        do_read("align", 32'h0000_125C, align_exp, 1'b0, 16'b1111, 4, FillA);

        $display("Result: errors=%0d of %0d checks", errors_q, checks_q);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts whole-line cache requests into multi-beat burst transfers to physical memory, and assembles returned bursts back into lines. Sits directly downstream of the cache's pmem port: the cache's 256-bit line read/write with single-cycle response maps onto a 4-beat, 64-bit burst protocol on the memory side.

## Interface
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width in bits; LINE_W must be an integer multiple of BURST_W
- ADDR_W, 32, address width
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- read_i  input  1  cache requests line fill; held until resp_o
- write_i  input  1  cache requests line writeback; held until resp_o
- address_i  input  ADDR_W  line address from cache; stable while request held
- line_i  input  LINE_W  writeback data; sampled on request acceptance
- line_o  output  LINE_W  assembled fill data; valid when resp_o=1
- resp_o  output  1  one-cycle completion pulse to cache
- address_o  output  ADDR_W  burst address to memory
- read_o  output  1  burst read request to memory
- write_o  output  1  burst write request to memory
- burst_o  output  BURST_W  current write beat
- burst_i  input  BURST_W  read beat from memory
- resp_i  input  1  memory beat strobe; one beat transferred per cycle with resp_i=1

## Operation
- BEATS = LINE_W/BURST_W (4 by default); beat k carries line bits [k*BURST_W +: BURST_W], beat 0 first.
- States: IDLE, READ, WRITE, DONE.
- IDLE: read_i=1 -> latch address_i, clear beat counter, go READ. write_i=1 (read_i=0) -> latch address_i and line_i, go WRITE. Both high -> read serviced. resp_i ignored.
- READ: read_o=1. Each cycle resp_i=1 -> burst_i written into beat slot [count], count++. On final beat -> DONE.
- WRITE: write_o=1, burst_o = latched line beat [count]. Each cycle resp_i=1 -> count++. On final beat -> DONE.
- Gaps allowed: resp_i=0 cycles inside a burst stall the count; request held.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, line_o holds assembled line (reads) or last fill (writes); -> IDLE. Requests in DONE ignored; cache drops its request in this cycle.
- line_o holds its value until next completed fill.
- Beat counter width clog2(BEATS); wraps to 0 on final beat.

## Timing
- All outputs registered. Reset values: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, state IDLE, count 0.
- Request seen in IDLE at cycle t -> read_o/write_o and address_o valid at t+1.
- Final beat at cycle n -> read_o/write_o low and resp_o high at n+1 -> IDLE at n+2.
- Minimum fill/writeback latency (consecutive beats): request at t, resp_o at t+1+BEATS = t+5.
- burst_o advances the cycle after each accepted beat.
- Reset mid-burst: return to IDLE next edge, partial line discarded, all outputs to reset values; memory must tolerate request withdrawal.
- Back-to-back: new request accepted earliest in the IDLE cycle following DONE.

## Configuration
- CACHELINE_ADAPTOR_LINE_ALIGN_EN defined: address_o low clog2(LINE_W/8) bits forced to 0 (5 bits default), so memory always sees line-aligned bursts.
- Undefined: address_o = latched address_i unmodified; cache is responsible for alignment.

## Structure
- Package cacheline_adaptor_pkg: state enum (IDLE, READ, WRITE, DONE), default LINE_W/BURST_W/ADDR_W constants, BEATS localparam derivation.
- Single module; no sub-module — counter and line buffer are small enough inline.

## Test plan
- Fill: read_i, address_i=0x0000_1240, resp_i high 4 consecutive cycles with burst_i 0x11..1,0x22..2,0x33..3,0x44..4 -> resp_o at t+5, line_o = {0x44..4,0x33..3,0x22..2,0x11..1}, read_o low same cycle.
- Writeback: write_i, line_i={D,C,B,A} (64-bit words) -> burst_o sequence A,B,C,D on successive resp_i beats, write_o high 4 cycles, resp_o one pulse.
- Stalled beats: resp_i pattern 1,0,0,1,1,0,1 during read -> correct 4-beat assembly, resp_o one cycle after the 7th cycle.
- Simultaneous read_i and write_i in IDLE -> read_o asserted, write_o stays 0.
- Reset asserted after 2 of 4 read beats -> next cycle all outputs 0, state IDLE; subsequent fill completes correctly.
- Alignment: address_i=0x0000_125C -> address_o=0x0000_1240 with CACHELINE_ADAPTOR_LINE_ALIGN_EN, 0x0000_125C without.
